// File: rtl/counter_sequencer_if.sv
// Request/grant and counter-control bundle for counter_sequencer.
// master: requesters plus the counter's value; slave: the sequencer itself.
interface counter_sequencer_if #(
    parameter int CNT_W  = 3,
    parameter int STEP_W = 4
);
    logic              req0;
    logic [CNT_W-1:0]  start0;
    logic              dir0;
    logic [STEP_W-1:0] steps0;
    logic              req1;
    logic [CNT_W-1:0]  start1;
    logic              dir1;
    logic [STEP_W-1:0] steps1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [CNT_W-1:0]  count;
    logic              set;
    logic [CNT_W-1:0]  setnum;
    logic              mode;
    logic              busy;
    logic              err;

    modport master (
        output req0, start0, dir0, steps0,
        output req1, start1, dir1, steps1,
        output count,
        input  gnt0, gnt1, done0, done1,
        input  set, setnum, mode, busy, err
    );

    modport slave (
        input  req0, start0, dir0, steps0,
        input  req1, start1, dir1, steps1,
        input  count,
        output gnt0, gnt1, done0, done1,
        output set, setnum, mode, busy, err
    );
endinterface

// File: rtl/counter_sequencer.sv
// Shares one external up/down counter between two requesters (round robin):
// load a start value, count N steps, then freeze and verify the final value.
//
// state | meaning
// IDLE  | counter frozen at hold value, waiting for a request
// LOAD  | counter loads the granted start value (one cycle)
// RUN   | counter free-runs in the granted direction for 'steps' edges
// DONE  | counter forced to expected value, final value checked (one cycle)
module counter_sequencer #(
    parameter int CNT_W  = 3,
    parameter int STEP_W = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    counter_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_set;
    logic [CNT_W-1:0]  r_setnum;
    logic              r_mode;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_busy;
    logic              r_err;
    logic [CNT_W-1:0]  r_hold;
    logic [CNT_W-1:0]  r_expected;
    logic              r_dir;
    logic [STEP_W-1:0] r_steps;
    logic [STEP_W-1:0] r_remaining;
    logic              r_id;
    logic              r_last;

    logic              w_any;
    logic              w_win;
    logic [CNT_W-1:0]  w_start;
    logic              w_dir;
    logic [STEP_W-1:0] w_steps;
    logic [CNT_W-1:0]  w_step_mod;
    logic [CNT_W-1:0]  w_expected;

    // With both requesting, the one not granted last wins.
    assign w_any      = bus.req0 | bus.req1;
    assign w_win      = (bus.req0 & bus.req1) ? ~r_last : bus.req1;
    assign w_start    = w_win ? bus.start1 : bus.start0;
    assign w_dir      = w_win ? bus.dir1   : bus.dir0;
    assign w_steps    = w_win ? bus.steps1 : bus.steps0;
    assign w_step_mod = CNT_W'(w_steps);
    assign w_expected = w_dir ? (w_start + w_step_mod) : (w_start - w_step_mod);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_set       <= 1'b1;
            r_setnum    <= '0;
            r_mode      <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_hold      <= '0;
            r_expected  <= '0;
            r_dir       <= 1'b0;
            r_steps     <= '0;
            r_remaining <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_set    <= 1'b1;
                    r_setnum <= r_hold;
                    if (w_any) begin
                        r_state    <= S_LOAD;
                        r_busy     <= 1'b1;
                        r_setnum   <= w_start;
                        r_dir      <= w_dir;
                        r_steps    <= w_steps;
                        r_id       <= w_win;
                        r_last     <= w_win;
                        r_expected <= w_expected;
                        r_gnt0     <= ~w_win;
                        r_gnt1     <= w_win;
                    end
                end
                S_LOAD: begin
                    if (r_steps != '0) begin
                        r_state     <= S_RUN;
                        r_set       <= 1'b0;
                        r_mode      <= r_dir;
                        r_remaining <= r_steps;
                    end else begin
                        r_state  <= S_DONE;
                        r_set    <= 1'b1;
                        r_setnum <= r_expected;
                        r_done0  <= ~r_id;
                        r_done1  <= r_id;
                    end
                end
                S_RUN: begin
                    r_remaining <= r_remaining - STEP_W'(1);
                    // set is registered, so this edge is still the last counting edge
                    if (r_remaining == STEP_W'(1)) begin
                        r_state  <= S_DONE;
                        r_set    <= 1'b1;
                        r_setnum <= r_expected;
                        r_done0  <= ~r_id;
                        r_done1  <= r_id;
                    end
                end
                S_DONE: begin
                    if (bus.count != r_expected) begin
                        r_err <= 1'b1;
                    end
                    r_hold  <= r_expected;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.set    = r_set;
    assign bus.setnum = r_setnum;
    assign bus.mode   = r_mode;
    assign bus.gnt0   = r_gnt0;
    assign bus.gnt1   = r_gnt1;
    assign bus.done0  = r_done0;
    assign bus.done1  = r_done1;
    assign bus.busy   = r_busy;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed and randomized bench for counter_sequencer with a behavioural
// counter and an arithmetic reference for final values and RUN lengths.
module tb_counter_sequencer;
    localparam int CNT_W  = 3;
    localparam int STEP_W = 4;
    localparam int MOD    = 1 << CNT_W;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   model_err = 0;
    int   last_final = 0;

    counter_sequencer_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus ();

    counter_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External counter; skip_arm makes it miss exactly one counting edge.
    logic [CNT_W-1:0] cnt_q = '0;
    bit skip_arm = 1'b0;
    bit skip_taken = 1'b0;
    always @(posedge clk) begin
        if (bus.set) cnt_q <= bus.setnum;
        else if (skip_arm && !skip_taken) skip_taken <= 1'b1;
        else if (bus.mode) cnt_q <= cnt_q + 1'b1;
        else cnt_q <= cnt_q - 1'b1;
    end
    assign bus.count = cnt_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_final(input int start, input int dir, input int steps);
        int v;
        v = dir ? start + steps : start - steps;
        return ((v % MOD) + MOD) % MOD;
    endfunction

    always @(negedge clk) begin
        check("excl_gnt_done", {30'd0, bus.gnt0 & bus.gnt1, bus.done0 & bus.done1}, 0);
    end

    task automatic set_req(input int id, input bit r, input int start, input int dir, input int steps);
        if (id == 0) begin
            bus.req0 = r; bus.start0 = CNT_W'(start); bus.dir0 = dir[0]; bus.steps0 = STEP_W'(steps);
        end else begin
            bus.req1 = r; bus.start1 = CNT_W'(start); bus.dir1 = dir[0]; bus.steps1 = STEP_W'(steps);
        end
    endtask

    task automatic run_cmd(input int id, input int start, input int dir, input int steps, input bit fault);
        int exp_final;
        int runs;
        bit got;
        exp_final = ref_final(start, dir, steps);
        set_req(id, 1'b1, start, dir, steps);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if ((id == 0) ? bus.gnt0 : bus.gnt1) got = 1'b1;
        end
        set_req(id, 1'b0, start, dir, steps);
        check("gnt_seen", 32'(got), 1);
        if (!got) return;
        check("gnt_other", 32'((id == 0) ? bus.gnt1 : bus.gnt0), 0);
        check("load_setnum", 32'(bus.setnum), start);
        check("load_set", 32'(bus.set), 1);
        check("load_busy", 32'(bus.busy), 1);
        runs = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if ((id == 0) ? bus.done0 : bus.done1) got = 1'b1;
            else if (!bus.set) begin
                runs++;
                check("run_mode", 32'(bus.mode), dir);
                if (!fault) check("run_count", 32'(bus.count), ref_final(start, dir, runs - 1));
            end
        end
        check("done_seen", 32'(got), 1);
        if (!got) return;
        check("run_cycles", runs, steps);
        check("done_other", 32'((id == 0) ? bus.done1 : bus.done0), 0);
        check("done_count", 32'(bus.count), fault ? ref_final(start, dir, steps - 1) : exp_final);
        check("done_setnum", 32'(bus.setnum), exp_final);
        check("done_busy", 32'(bus.busy), 1);
        check("done_err_before", 32'(bus.err), model_err);
        if (fault) model_err = 1;
        last_final = exp_final;
        @(negedge clk);
        check("post_err", 32'(bus.err), model_err);
        check("post_busy", 32'(bus.busy), 0);
        check("hold_count", 32'(bus.count), exp_final);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        #1;
        check("rst_set", 32'(bus.set), 1);
        check("rst_setnum", 32'(bus.setnum), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_done", {30'd0, bus.done0, bus.done1}, 0);
        check("rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 0);
        model_err = 0;
        last_final = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_count", 32'(bus.count), 0);
        clr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev_code[$];
        int ev_cyc[$];
        int exp_codes[5];
        bit got;
        set_req(0, 1'b0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        check("rst_mode", 32'(bus.mode), 0);
        @(negedge clk);

        // load 2, up 3 -> 5
        run_cmd(0, 2, 1, 3, 1'b0);
        // down across wrap 1 -> 5, then zero steps
        run_cmd(1, 1, 0, 4, 1'b0);
        run_cmd(1, 6, 0, 0, 1'b0);
        // longest run
        run_cmd(0, 7, 1, 15, 1'b0);

        // missed step -> sticky err
        skip_arm = 1'b1;
        run_cmd(0, 0, 1, 4, 1'b1);
        skip_arm = 1'b0;
        run_cmd(1, 3, 1, 2, 1'b0);
        check("err_sticky", 32'(bus.err), 1);
        @(negedge clk);
        do_reset();
        @(negedge clk);
        check("err_cleared", 32'(bus.err), 0);

        // reset in the middle of RUN
        set_req(0, 1'b1, 1, 1, 10);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.gnt0) got = 1'b1;
        end
        set_req(0, 1'b0, 1, 1, 10);
        check("midrun_gnt", 32'(got), 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("midrun_running", 32'(bus.set), 0);
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check("abandon_no_done", 32'(bus.done0), 0);
            check("abandon_hold", 32'(bus.count), 0);
        end

        // both requesters held from reset
        clr = 1'b0;
        set_req(0, 1'b1, 3, 1, 2);
        set_req(1, 1'b1, 4, 0, 1);
        @(negedge clk);
        clr = 1'b1;
        model_err = 0;
        for (int c = 0; c < 60 && ev_code.size() < 5; c++) begin
            @(negedge clk);
            if (bus.gnt0)  begin ev_code.push_back(0); ev_cyc.push_back(c); end
            if (bus.done0) begin ev_code.push_back(1); ev_cyc.push_back(c); end
            if (bus.gnt1)  begin ev_code.push_back(2); ev_cyc.push_back(c); bus.req1 = 1'b0; end
            if (bus.done1) begin ev_code.push_back(3); ev_cyc.push_back(c); end
        end
        bus.req0 = 1'b0;
        exp_codes = '{0, 1, 2, 3, 0};
        check("rr_events", ev_code.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < ev_code.size()) check("rr_order", ev_code[k], exp_codes[k]);
        end
        if (ev_cyc.size() == 5) begin
            check("rr_gap01", ev_cyc[2] - ev_cyc[1], 2);
            check("rr_gap12", ev_cyc[4] - ev_cyc[3], 2);
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.done0) got = 1'b1;
        end
        check("rr_drain", 32'(got), 1);
        @(negedge clk);
        check("rr_err", 32'(bus.err), 0);
        check("rr_hold", 32'(bus.count), ref_final(3, 1, 2));

        // randomized commands
        for (int n = 0; n < 24; n++) begin
            int id, st, dr, sp, idle;
            id = $urandom_range(0, 1);
            st = $urandom_range(0, MOD - 1);
            dr = $urandom_range(0, 1);
            sp = $urandom_range(0, (1 << STEP_W) - 1);
            run_cmd(id, st, dr, sp, 1'b0);
            idle = $urandom_range(0, 3);
            for (int c = 0; c < idle; c++) begin
                @(negedge clk);
                check("idle_hold", 32'(bus.count), last_final);
                check("idle_busy", 32'(bus.busy), 0);
            end
        end
        check("final_err", 32'(bus.err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
